// File: rtl/io_counter_bank.sv
// Bank of independent up/down wrap counters sharing one prescaler.
// Each lane drives a one-cycle terminal pulse and a toggle pin on every wrap.
module io_counter_lane #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             terminal,
  output logic             pin_out
);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count    <= '0;
      terminal <= 1'b0;
      pin_out  <= 1'b0;
    end else if (load) begin
      count    <= load_value;
      terminal <= 1'b0;
    end else if (tick && enable) begin
      // >= so a loaded value above limit wraps on the next up tick
      if (up_down) begin
        if (count >= limit) begin
          count    <= '0;
          terminal <= 1'b1;
          pin_out  <= ~pin_out;
        end else begin
          count    <= count + 1'b1;
          terminal <= 1'b0;
        end
      end else begin
        if (count == '0) begin
          count    <= limit;
          terminal <= 1'b1;
          pin_out  <= ~pin_out;
        end else begin
          count    <= count - 1'b1;
          terminal <= 1'b0;
        end
      end
    end else begin
      terminal <= 1'b0;
    end
  end
endmodule

module io_counter_bank #(
  parameter int WIDTH         = 8,
  parameter int CHANNELS      = 4,
  parameter int PRESCALE_BITS = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       up_down,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] load_value,
  input  logic [CHANNELS*WIDTH-1:0] limit,
  input  logic [PRESCALE_BITS-1:0]  prescale,
  output logic [CHANNELS*WIDTH-1:0] count_out,
  output logic [CHANNELS-1:0]       terminal,
  output logic [CHANNELS-1:0]       pin_out
);
  logic [PRESCALE_BITS-1:0]         presc_cnt;
  logic                             tick;
  logic [CHANNELS-1:0][WIDTH-1:0]   load_v, limit_v, count_v;

  // >= compare: lowering prescale below presc_cnt ticks next cycle, no lockup
  assign tick = (presc_cnt >= prescale);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  presc_cnt <= '0;
    else if (tick) presc_cnt <= '0;
    else           presc_cnt <= presc_cnt + 1'b1;
  end

  assign load_v    = load_value;
  assign limit_v   = limit;
  assign count_out = count_v;

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
      io_counter_lane #(.WIDTH(WIDTH)) u_lane (
        .clock      (clock),
        .reset_n    (reset_n),
        .tick       (tick),
        .enable     (enable[i]),
        .up_down    (up_down[i]),
        .load       (load[i]),
        .load_value (load_v[i]),
        .limit      (limit_v[i]),
        .count      (count_v[i]),
        .terminal   (terminal[i]),
        .pin_out    (pin_out[i])
      );
    end
  endgenerate
endmodule

// File: tb/tb_io_counter_bank.sv
// Scoreboard bench for io_counter_bank: expected state queued per driven cycle,
// popped and compared one time unit after the following rising edge.
module tb_io_counter_bank;
  localparam int W  = 8;
  localparam int CH = 4;
  localparam int PB = 4;

  typedef struct packed {
    logic [CH*W-1:0] cnt;
    logic [CH-1:0]   term;
    logic [CH-1:0]   pin;
  } exp_t;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [CH-1:0]   enable, up_down, load;
  logic [CH*W-1:0] load_value, limit;
  logic [PB-1:0]   prescale;
  logic [CH*W-1:0] count_out;
  logic [CH-1:0]   terminal, pin_out;

  exp_t sb[$];
  exp_t e, got;
  int   n_chk = 0;
  int   n_fail = 0;

  io_counter_bank #(.WIDTH(W), .CHANNELS(CH), .PRESCALE_BITS(PB)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .up_down(up_down),
    .load(load), .load_value(load_value), .limit(limit), .prescale(prescale),
    .count_out(count_out), .terminal(terminal), .pin_out(pin_out)
  );

  always #5 clock = ~clock;

  // Reset pulse placed between edges; all inputs back to a quiet default.
  task automatic apply_reset();
    @(posedge clock); #1;
    reset_n = 1'b0; enable = '0; up_down = '1; load = '0;
    load_value = '0; limit = '1; prescale = '0;
    #2; reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = '1; up_down = '1; load = '0;
    load_value = '0; limit = '1; prescale = '0;
    repeat (3) @(posedge clock);
    #1;
    n_chk++; if (count_out !== '0) begin n_fail++; $display("FAIL reset_count got=%h exp=0", count_out); end
    n_chk++; if (terminal !== '0)  begin n_fail++; $display("FAIL reset_terminal got=%b exp=0", terminal); end
    n_chk++; if (pin_out !== '0)   begin n_fail++; $display("FAIL reset_pin got=%b exp=0", pin_out); end
  endtask

  task automatic test_free_run();
    logic [W-1:0] c;
    apply_reset();
    enable = '1; up_down = '1; limit = '1; prescale = '0;
    for (int k = 1; k <= 257; k++) begin
      c = W'(k);
      e.cnt  = {CH{c}};
      e.term = (k == 256) ? '1 : '0;
      e.pin  = (k >= 256) ? '1 : '0;
      sb.push_back(e);
      @(posedge clock); #1;
      e = sb.pop_front(); got = {count_out, terminal, pin_out};
      n_chk++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL free_run k=%0d got cnt=%h t=%b p=%b exp cnt=%h t=%b p=%b",
                 k, got.cnt, got.term, got.pin, e.cnt, e.term, e.pin);
      end
    end
  endtask

  task automatic test_prescaled();
    int lower[9] = '{0, 0, 0, 0, 0, 1, 1, 1, 2};
    apply_reset();
    prescale = 4'd3; enable = 4'b0001; limit[7:0] = 8'd5;
    for (int k = 1; k <= 50; k++) begin
      e.cnt  = '0;
      e.cnt[7:0] = W'((k / 4) % 6);
      e.term = {3'b000, (k % 24 == 0)};
      e.pin  = {3'b000, ((k / 24) % 2 == 1)};
      sb.push_back(e);
      @(posedge clock); #1;
      e = sb.pop_front(); got = {count_out, terminal, pin_out};
      n_chk++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL prescaled k=%0d got cnt=%h t=%b p=%b exp cnt=%h t=%b p=%b",
                 k, got.cnt, got.term, got.pin, e.cnt, e.term, e.pin);
      end
    end
    // Drop prescale below the running prescaler count mid-period.
    apply_reset();
    prescale = 4'd7; enable = 4'b0001;
    for (int k = 0; k < 9; k++) begin
      if (k == 5) prescale = 4'd2;
      e.cnt = '0; e.cnt[7:0] = W'(lower[k]); e.term = '0; e.pin = '0;
      sb.push_back(e);
      @(posedge clock); #1;
      e = sb.pop_front(); got = {count_out, terminal, pin_out};
      n_chk++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL prescale_lower k=%0d got cnt=%h exp cnt=%h", k, got.cnt, e.cnt);
      end
    end
  endtask

  task automatic test_down_wrap();
    int seq[5] = '{2, 1, 0, 9, 8};
    apply_reset();
    enable = 4'b0010; up_down = 4'b1101;
    limit[15:8] = 8'd9; load_value[15:8] = 8'd2; load = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      if (k == 1) load = '0;
      e.cnt = '0; e.cnt[15:8] = W'(seq[k]);
      e.term = (k == 3) ? 4'b0010 : 4'b0000;
      e.pin  = (k >= 3) ? 4'b0010 : 4'b0000;
      sb.push_back(e);
      @(posedge clock); #1;
      e = sb.pop_front(); got = {count_out, terminal, pin_out};
      n_chk++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL down_wrap k=%0d got cnt=%h t=%b p=%b exp cnt=%h t=%b p=%b",
                 k, got.cnt, got.term, got.pin, e.cnt, e.term, e.pin);
      end
    end
  endtask

  task automatic test_load_priority();
    int seq[5] = '{1, 2, 3, 8'h80, 8'h81};
    apply_reset();
    enable = 4'b0001; load_value[7:0] = 8'h80;
    for (int k = 0; k < 5; k++) begin
      load = (k == 3) ? 4'b0001 : 4'b0000;
      e.cnt = '0; e.cnt[7:0] = W'(seq[k]); e.term = '0; e.pin = '0;
      sb.push_back(e);
      @(posedge clock); #1;
      e = sb.pop_front(); got = {count_out, terminal, pin_out};
      n_chk++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL load_priority k=%0d got cnt=%h t=%b exp cnt=%h t=%b",
                 k, got.cnt, got.term, e.cnt, e.term);
      end
    end
  endtask

  task automatic test_out_of_range();
    int seq[3] = '{200, 0, 1};
    apply_reset();
    enable = 4'b0001; limit[7:0] = 8'd10; load_value[7:0] = 8'd200;
    for (int k = 0; k < 3; k++) begin
      load = (k == 0) ? 4'b0001 : 4'b0000;
      e.cnt = '0; e.cnt[7:0] = W'(seq[k]);
      e.term = (k == 1) ? 4'b0001 : 4'b0000;
      e.pin  = (k >= 1) ? 4'b0001 : 4'b0000;
      sb.push_back(e);
      @(posedge clock); #1;
      e = sb.pop_front(); got = {count_out, terminal, pin_out};
      n_chk++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL out_of_range k=%0d got cnt=%h t=%b p=%b exp cnt=%h t=%b p=%b",
                 k, got.cnt, got.term, got.pin, e.cnt, e.term, e.pin);
      end
    end
  endtask

  task automatic test_limit_zero();
    apply_reset();
    enable = 4'b1010; up_down = 4'b1101;
    limit[31:24] = 8'd0; limit[15:8] = 8'd0;
    for (int k = 1; k <= 4; k++) begin
      e.cnt = '0; e.term = 4'b1010;
      e.pin = (k % 2 == 1) ? 4'b1010 : 4'b0000;
      sb.push_back(e);
      @(posedge clock); #1;
      e = sb.pop_front(); got = {count_out, terminal, pin_out};
      n_chk++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL limit_zero k=%0d got cnt=%h t=%b p=%b exp cnt=%h t=%b p=%b",
                 k, got.cnt, got.term, got.pin, e.cnt, e.term, e.pin);
      end
    end
  endtask

  task automatic test_async_reset_independence();
    int seq[5] = '{0, 1, 2, 3, 0};
    apply_reset();
    enable = 4'b0100; limit[23:16] = 8'd3;
    load_value = {8'd40, 8'd0, 8'd20, 8'd10}; load = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      if (k == 1) load = '0;
      e.cnt  = {8'd40, W'(seq[k]), 8'd20, 8'd10};
      e.term = (k == 4) ? 4'b0100 : 4'b0000;
      e.pin  = (k == 4) ? 4'b0100 : 4'b0000;
      sb.push_back(e);
      @(posedge clock); #1;
      e = sb.pop_front(); got = {count_out, terminal, pin_out};
      n_chk++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL independence k=%0d got cnt=%h t=%b p=%b exp cnt=%h t=%b p=%b",
                 k, got.cnt, got.term, got.pin, e.cnt, e.term, e.pin);
      end
    end
    // terminal[2] is high now; reset between edges must clear it at once.
    #2; reset_n = 1'b0; #1;
    n_chk++; if (count_out !== '0) begin n_fail++; $display("FAIL async_count got=%h exp=0", count_out); end
    n_chk++; if (terminal !== '0)  begin n_fail++; $display("FAIL async_terminal got=%b exp=0", terminal); end
    n_chk++; if (pin_out !== '0)   begin n_fail++; $display("FAIL async_pin got=%b exp=0", pin_out); end
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_prescaled();
    test_down_wrap();
    test_load_priority();
    test_out_of_range();
    test_limit_zero();
    test_async_reset_independence();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
